// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receive path.
package sipo_pkg;

    // Framing sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of the bit counter for an n-bit frame (never narrower than 1 bit)
    function automatic int cnt_width(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Even parity of a word, for consumers that protect the holding register
    function automatic logic word_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// N-bit serial-in shift register with clear, first-bit load and selectable direction.
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [N-1:0] next_word
);

    logic [N-1:0] sh_r;
    logic [N-1:0] shifted_s;
    logic [N-1:0] first_s;

    // Candidate values: shifted-in word and a fresh word holding only the first bit
    always_comb begin
        shifted_s = {N{1'b0}};
        first_s   = {N{1'b0}};
        if (MSB_FIRST) begin
            shifted_s = {sh_r[N-2:0], din};
            first_s   = {{(N-1){1'b0}}, din};
        end else begin
            shifted_s = {din, sh_r[N-1:1]};
            first_s   = {din, {(N-1){1'b0}}};
        end
    end

    // Shift register state: clear wins, a clear with a same-cycle bit starts a new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= {N{1'b0}};
        end else if (clr && shift_en) begin
            sh_r <= first_s;
        end else if (clr) begin
            sh_r <= {N{1'b0}};
        end else if (shift_en) begin
            sh_r <= shifted_s;
        end else begin
            sh_r <= sh_r;
        end
    end

    // The completed word must include the bit arriving this cycle
    assign next_word = shifted_s;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer: frames a serial stream into N-bit words and hands them
// downstream through a valid/ready holding register with overrun reporting.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int N          = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in,
    input  logic                    in_en,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    out_ready,
    output logic [N-1:0]            out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic [cnt_width(N)-1:0] bit_cnt,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_r;
    logic [CW-1:0] bit_cnt_r;
    logic [N-1:0]  out_data_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          frame_done_r;
    logic          overrun_r;

    logic [N-1:0]  word_s;
    logic          complete_s;
    logic          sh_clr_s;
    logic          sh_shift_s;
    logic          load_s;
    logic          drop_s;

    sipo_shift_reg #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (sh_clr_s),
        .shift_en  (sh_shift_s),
        .din       (in),
        .next_word (word_s)
    );

    // Per-cycle decode with priority abort > start > qualified bit
    always_comb begin
        complete_s = 1'b0;
        sh_clr_s   = 1'b0;
        sh_shift_s = 1'b0;
        if (abort) begin
            sh_clr_s = 1'b1;
        end else if (start) begin
            sh_clr_s   = 1'b1;
            sh_shift_s = in_en;
        end else if ((state_r == SHIFT) && in_en) begin
            if (bit_cnt_r == CNT_LAST) begin
                complete_s = 1'b1;
                sh_clr_s   = 1'b1;
            end else begin
                sh_shift_s = 1'b1;
            end
        end else begin
            sh_clr_s   = 1'b0;
            sh_shift_s = 1'b0;
        end
        load_s = complete_s && (!out_valid_r || out_ready);
        drop_s = complete_s && out_valid_r && !out_ready;
    end

    // Framing FSM, bit counter, holding register and handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            bit_cnt_r    <= CNT_ZERO;
            out_data_r   <= {N{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_done_r <= complete_s;
            overrun_r    <= drop_s;

            if (load_s) begin
                out_data_r  <= word_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (abort) begin
                state_r   <= IDLE;
                busy_r    <= 1'b0;
                bit_cnt_r <= CNT_ZERO;
            end else if (start) begin
                state_r   <= SHIFT;
                busy_r    <= 1'b1;
                bit_cnt_r <= in_en ? CNT_ONE : CNT_ZERO;
            end else if (complete_s) begin
                bit_cnt_r <= CNT_ZERO;
                if (CONTINUOUS) begin
                    state_r <= SHIFT;
                    busy_r  <= 1'b1;
                end else begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            end else if ((state_r == SHIFT) && in_en) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end else begin
                state_r   <= state_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign bit_cnt    = bit_cnt_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Receive-side sequencer for the serial-in/parallel-out shift datapath. It frames a serial bit stream into N-bit words:
- waits for a start marker, counts N qualified bits, then transfers the assembled word to a holding register;
- presents the word downstream with a valid/ready handshake;
- flags overrun when the consumer stalls.
It sits between the serial line front-end and any parallel consumer.

Parameters:
N, 8, word width / bits per frame (N >= 2)
MSB_FIRST, 1, 1 = first received bit lands in out_data[N-1]; 0 = first bit lands in out_data[0]
CONTINUOUS, 0, 1 = after a frame completes, next frame starts immediately without a new start; 0 = return to IDLE

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
in  in  1  serial data bit
in_en  in  1  bit strobe; in is sampled only when in_en=1
start  in  1  frame start marker (level sampled per cycle)
abort  in  1  discard the partial frame and return to IDLE
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  N  assembled parallel word (holding register)
out_valid  out  1  out_data is valid
busy  out  1  frame in progress (state==SHIFT)
bit_cnt  out  $clog2(N)  bits captured in the current frame
frame_done  out  1  one-cycle pulse, one cycle after the last bit of a frame
overrun  out  1  one-cycle pulse: completed frame dropped because the holding register is full

Behaviour:
- Reset (rst=0, async): state=IDLE; shift reg, out_data, bit_cnt = 0; out_valid, busy, frame_done, overrun = 0.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 -> SHIFT, bit_cnt=0.
  - If in_en=1 in the same cycle, that bit is captured as bit 0 and bit_cnt=1 next cycle.
  - in_en without start is ignored.
- SHIFT:
  - Each in_en=1 shifts in one bit; bit_cnt increments.
  - Shift order: MSB_FIRST=1 uses {sh[N-2:0],in}; MSB_FIRST=0 uses {in,sh[N-1:1]}.
  - in_en=0 cycles hold all state; gaps are unlimited.
- Completion is in_en=1 while bit_cnt==N-1. In the next cycle:
  - frame_done=1;
  - bit_cnt=0;
  - state = SHIFT if CONTINUOUS=1, else IDLE.
  - The word includes the last bit. Latency from last in_en to out_valid/frame_done is 1 clock.
- Holding-register load on completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the completion cycle: out_data <= new word, out_valid <= 1.
  - If out_valid=1 and out_ready=0: new word discarded, out_data/out_valid unchanged, overrun=1 for one cycle. frame_done still pulses.
- Handshake:
  - out_valid stays 1 and out_data stays stable until a cycle with out_valid&&out_ready.
  - Outside a completion load, that handshake cycle clears out_valid next cycle.
  - out_ready while out_valid=0 has no effect.
- start while in SHIFT restarts the frame: partial bits discarded, bit_cnt=0, and a same-cycle in_en bit is captured as bit 0.
- abort=1 (any state): next state=IDLE, bit_cnt=0, partial frame discarded, no frame_done.
  - Priority over start and over a completing in_en.
  - Holding register and out_valid are unaffected.
- Priority per cycle: abort > start > in_en shift/complete.
- busy = (state==SHIFT), registered.
- Reset mid-frame or mid-handshake: immediate return to reset values; the partial frame and the held word are lost.

Decomposition:
- Shared package sipo_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the function/localparam for counter width, CW = $clog2(N).
- One sub-module is natural: sipo_shift_reg (N-bit shift register with shift-enable, clear, and MSB_FIRST direction parameter).
- The FSM, bit counter, holding register and handshake stay in sipo_rx_ctrl.

Test Plan:
- N=8, MSB_FIRST=1, out_ready=1, start with first bit, then bits 1,0,1,0,0,1,0,1 on consecutive in_en -> out_data=0xA5, out_valid=1 and frame_done=1 exactly 1 clock after 8th bit; out_valid cleared the following cycle; busy=0 afterwards.
- MSB_FIRST=0, same framing, bits 1,0,1,1,0,0,0,1 with in_en high every other cycle -> out_data=0x8D; bit_cnt holds through gaps; latency still 1 clock after last in_en.
- out_ready=0, frames 0x3C then 0xFF -> out_data stays 0x3C, out_valid=1, overrun pulses once, frame_done pulses twice; then out_ready=1 for one cycle -> out_valid=0.
- Start, 4 bits, abort together with the 5th in_en, then new frame 0x0F -> no frame_done for the aborted frame; out_data=0x0F; abort-cycle bit not captured.
- CONTINUOUS=1: one start, then 16 back-to-back bits 0x12, 0x34 with out_ready=1 -> two valid words 0x12 then 0x34, 8 clocks apart; busy stays 1; no overrun.
- Assert rst=0 after 5 bits of a frame with out_valid=1 holding 0x55 -> all outputs 0 asynchronously (before next clk edge); after release, a full frame 0xC3 is received correctly.
